// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive parser: FSM states, frame
// geometry, CRC-32 constants and the byte-wise CRC update function.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        DROP,
        STATUS
    } state_t;

    localparam int          ETH_HDR_LEN = 14;
    localparam int          ETH_FCS_LEN = 4;

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;

    // Reflected CRC-32 advanced by one byte, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32.sv
// Byte-wise reflected CRC-32 register. 'init' restarts the CRC; when it is
// raised together with crc_en the byte is folded into a fresh CRC_INIT so
// the first byte of a frame is never lost.
module crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        crc_en,
    input  logic        init,
    output logic [31:0] crc_out
);

    logic [31:0] r_crc;
    logic [31:0] w_base;

    assign w_base  = init ? CRC_INIT : r_crc;
    assign crc_out = r_crc;

    // CRC state: restart, fold in a byte, or hold.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= CRC_INIT;
        end else if (crc_en) begin
            r_crc <= crc32_byte(w_base, data_in);
        end else if (init) begin
            r_crc <= CRC_INIT;
        end
    end

endmodule

// File: rtl/eth_rx_parser.sv
// Ethernet receive parser: captures the 14-byte header, filters on the
// destination MAC, strips the FCS through a 4-byte delay line, checks the
// CRC-32 and length, and reports a per-frame status pulse.
module eth_rx_parser
    import eth_pkg::*;
#(
    parameter int          MAX_PAYLOAD    = 1500,
    parameter int          MIN_PAYLOAD    = 46,
    parameter bit          ADDR_FILTER_EN = 1'b1,
    parameter logic [47:0] LOCAL_MAC      = 48'h02_00_00_00_00_01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  frame_in,
    input  logic        valid,
    input  logic        frame_last,
    output logic [7:0]  payload_out,
    output logic        payload_valid,
    output logic        payload_last,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] ethertype,
    output logic        hdr_valid,
    output logic        frame_done,
    output logic        error_flag,
    output logic        err_crc,
    output logic        err_len,
    output logic        dropped
);

    localparam int          HDR_W        = ETH_HDR_LEN * 8;
    localparam int          LINE_W       = ETH_FCS_LEN * 8;
    localparam logic [2:0]  LINE_DEPTH   = 3'(ETH_FCS_LEN);
    localparam logic [15:0] HDR_LAST_IDX = 16'(ETH_HDR_LEN - 1);
    localparam logic [15:0] MIN_TOTAL    = 16'(MIN_PAYLOAD + ETH_HDR_LEN + ETH_FCS_LEN);
    localparam logic [15:0] MAX_TOTAL    = 16'(MAX_PAYLOAD + ETH_HDR_LEN + ETH_FCS_LEN);

    state_t              r_state;
    logic [15:0]         r_cnt;        // bytes of the current frame seen so far
    logic [HDR_W-1:0]    r_hdr;        // {dst_mac, src_mac, ethertype}
    logic [LINE_W-1:0]   r_line;       // FCS-stripping delay line, newest in LSB
    logic [2:0]          r_fill;       // occupied delay-line slots
    logic                r_filt;       // frame rejected by the address filter
    logic                r_trunc;      // frame cut off for exceeding MAX_PAYLOAD
    logic                r_runt;       // frame ended inside the header

    logic [7:0]          r_pay_data;
    logic                r_pay_valid;
    logic                r_pay_last;
    logic                r_hdr_valid;
    logic                r_frame_done;
    logic                r_error_flag;
    logic                r_err_crc;
    logic                r_err_len;
    logic                r_dropped;

    logic                w_start;
    logic [15:0]         w_cnt_next;
    logic [47:0]         w_dst_seen;
    logic                w_dst_filtered;
    logic [31:0]         w_crc;
    logic                w_len_bad;
    logic                w_stat_err_crc;
    logic                w_stat_err_len;

    // A byte arriving in IDLE, or during the STATUS cycle of the previous
    // frame, is header byte 0 of a new frame.
    assign w_start    = valid && (r_state == IDLE || r_state == STATUS);

    // Saturating byte count: oversized frames must never wrap back into range.
    assign w_cnt_next = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    // When byte 13 arrives, bytes 0..12 sit in the low 104 bits of r_hdr, so
    // the destination MAC is already complete.
    assign w_dst_seen     = r_hdr[HDR_W-9 -: 48];
    assign w_dst_filtered = ADDR_FILTER_EN && (w_dst_seen != LOCAL_MAC)
                                           && (w_dst_seen != BCAST_MAC);

    // Status is evaluated in STATUS, where the CRC already includes the last
    // FCS byte and r_cnt holds the total frame length.
    assign w_len_bad      = (r_cnt < MIN_TOTAL) || (r_cnt > MAX_TOTAL);
    assign w_stat_err_len = !r_filt && (r_trunc || r_runt || w_len_bad);
    assign w_stat_err_crc = !r_filt && (w_crc != CRC_RESIDUE);

    crc32 u_crc (
        .clk     (clk),
        .rst     (rst),
        .data_in (frame_in),
        .crc_en  (valid),
        .init    (w_start),
        .crc_out (w_crc)
    );

    assign payload_out   = r_pay_data;
    assign payload_valid = r_pay_valid;
    assign payload_last  = r_pay_last;
    assign dst_mac       = r_hdr[HDR_W-1 -: 48];
    assign src_mac       = r_hdr[HDR_W-49 -: 48];
    assign ethertype     = r_hdr[15:0];
    assign hdr_valid     = r_hdr_valid;
    assign frame_done    = r_frame_done;
    assign error_flag    = r_error_flag;
    assign err_crc       = r_err_crc;
    assign err_len       = r_err_len;
    assign dropped       = r_dropped;

    // Parser FSM with registered outputs; later assignments in the block
    // override the per-cycle pulse defaults set at its top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 16'd0;
            r_hdr        <= '0;
            // NOTE: the delay line is a handful of flops rather than a RAM,
            // so it is cleared by reset along with the rest of the state.
            r_line       <= '0;
            r_fill       <= 3'd0;
            r_filt       <= 1'b0;
            r_trunc      <= 1'b0;
            r_runt       <= 1'b0;
            r_pay_data   <= 8'd0;
            r_pay_valid  <= 1'b0;
            r_pay_last   <= 1'b0;
            r_hdr_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_error_flag <= 1'b0;
            r_err_crc    <= 1'b0;
            r_err_len    <= 1'b0;
            r_dropped    <= 1'b0;
        end else begin
            r_pay_valid  <= 1'b0;
            r_pay_last   <= 1'b0;
            r_hdr_valid  <= 1'b0;
            r_frame_done <= 1'b0;

            if (r_state == STATUS) begin
                r_frame_done <= 1'b1;
                r_err_crc    <= w_stat_err_crc;
                r_err_len    <= w_stat_err_len;
                r_dropped    <= r_filt || r_trunc || r_runt;
                r_error_flag <= r_error_flag || w_stat_err_crc || w_stat_err_len;
                r_state      <= IDLE;
            end

            if (w_start) begin
                r_cnt   <= 16'd1;
                r_hdr   <= {r_hdr[HDR_W-9:0], frame_in};
                r_fill  <= 3'd0;
                r_filt  <= 1'b0;
                r_trunc <= 1'b0;
                r_runt  <= 1'b0;
                if (frame_last) begin
                    r_runt  <= 1'b1;
                    r_state <= STATUS;
                end else begin
                    r_state <= HDR;
                end
            end else if (valid) begin
                r_cnt <= w_cnt_next;
                case (r_state)
                    HDR: begin
                        r_hdr <= {r_hdr[HDR_W-9:0], frame_in};
                        if (r_cnt == HDR_LAST_IDX) begin
                            r_hdr_valid <= 1'b1;
                            r_filt      <= w_dst_filtered;
                            if (frame_last) begin
                                r_state <= STATUS;
                            end else if (w_dst_filtered) begin
                                r_state <= DROP;
                            end else begin
                                r_state <= PAYLOAD;
                            end
                        end else if (frame_last) begin
                            r_runt  <= 1'b1;
                            r_state <= STATUS;
                        end
                    end

                    PAYLOAD: begin
                        if (r_cnt >= MAX_TOTAL) begin
                            // This byte takes the frame past the maximum:
                            // stop emitting at once, without payload_last.
                            r_trunc <= 1'b1;
                            r_state <= frame_last ? STATUS : DROP;
                        end else begin
                            r_line <= {r_line[LINE_W-9:0], frame_in};
                            if (r_fill == LINE_DEPTH) begin
                                r_pay_valid <= 1'b1;
                                r_pay_data  <= r_line[LINE_W-1 -: 8];
                                r_pay_last  <= frame_last;
                            end else begin
                                r_fill <= r_fill + 3'd1;
                            end
                            if (frame_last) begin
                                r_state <= STATUS;
                            end
                        end
                    end

                    DROP: begin
                        if (frame_last) begin
                            r_state <= STATUS;
                        end
                    end

                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_parser.sv
// Directed scoreboard bench for eth_rx_parser: each frame's expected header,
// payload bytes and status are queued when it is driven and popped as the
// DUT produces them.
module tb_eth_rx_parser;

    localparam int          MAXP      = 1500;
    localparam int          MINP      = 46;
    localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC_MAC   = 48'h0A_0B_0C_0D_0E_0F;

    typedef logic [7:0] bq_t[$];
    typedef struct packed { logic [7:0] data; logic last; } pay_t;
    typedef struct packed { logic err_crc; logic err_len; logic dropped; logic chk_crc; } stat_t;
    typedef struct packed { logic [47:0] dst; logic [47:0] src; logic [15:0] etype; } hdr_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  frame_in;
    logic        valid;
    logic        frame_last;
    logic [7:0]  payload_out;
    logic        payload_valid;
    logic        payload_last;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        hdr_valid;
    logic        frame_done;
    logic        error_flag;
    logic        err_crc;
    logic        err_len;
    logic        dropped;

    pay_t  exp_pay[$];
    stat_t exp_stat[$];
    hdr_t  exp_hdr[$];
    int    total = 0;
    int    bad   = 0;
    logic  exp_flag = 1'b0;

    eth_rx_parser dut (
        .clk           (clk),
        .rst           (rst),
        .frame_in      (frame_in),
        .valid         (valid),
        .frame_last    (frame_last),
        .payload_out   (payload_out),
        .payload_valid (payload_valid),
        .payload_last  (payload_last),
        .dst_mac       (dst_mac),
        .src_mac       (src_mac),
        .ethertype     (ethertype),
        .hdr_valid     (hdr_valid),
        .frame_done    (frame_done),
        .error_flag    (error_flag),
        .err_crc       (err_crc),
        .err_len       (err_len),
        .dropped       (dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tb_crc(input bq_t f);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (f[i]) begin
            c = c ^ {24'd0, f[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    // Header, payload (seed, seed+1, ...) and a little-endian FCS; optionally
    // the last FCS byte is inverted.
    function automatic bq_t build_frame(input logic [47:0] dst, input logic [15:0] etype,
                                        input int plen, input logic [7:0] seed, input bit corrupt);
        bq_t f;
        logic [31:0] fcs;
        for (int i = 0; i < 6; i++) f.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) f.push_back(SRC_MAC[47-8*i -: 8]);
        f.push_back(etype[15:8]);
        f.push_back(etype[7:0]);
        for (int i = 0; i < plen; i++) f.push_back(8'(int'(seed) + i));
        fcs = ~tb_crc(f);
        for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
        if (corrupt) f[f.size()-1] = f[f.size()-1] ^ 8'hFF;
        return f;
    endfunction

    // Reference behaviour of one complete frame, pushed onto the scoreboard.
    task automatic expect_frame(input bq_t f);
        int    n = f.size();
        int    l;
        hdr_t  h;
        stat_t s;
        pay_t  p;
        logic  filt;
        logic  crc_ok;
        crc_ok = (tb_crc(f) == 32'hDEBB_20E3);
        if (n < 14) begin
            s.err_crc = 1'b0; s.err_len = 1'b1; s.dropped = 1'b1; s.chk_crc = 1'b0;
            exp_stat.push_back(s);
            return;
        end
        h.dst = '0; h.src = '0;
        for (int i = 0; i < 6; i++) h.dst = {h.dst[39:0], f[i]};
        for (int i = 6; i < 12; i++) h.src = {h.src[39:0], f[i]};
        h.etype = {f[12], f[13]};
        exp_hdr.push_back(h);
        filt = (h.dst != LOCAL_MAC) && (h.dst != BCAST);
        s.chk_crc = 1'b1;
        if (filt) begin
            s.err_crc = 1'b0; s.err_len = 1'b0; s.dropped = 1'b1;
        end else if (n > MAXP + 18) begin
            for (int i = 0; i < MAXP; i++) begin
                p.data = f[14+i]; p.last = 1'b0; exp_pay.push_back(p);
            end
            s.err_crc = !crc_ok; s.err_len = 1'b1; s.dropped = 1'b1;
        end else begin
            l = n - 18;
            for (int i = 0; i < l; i++) begin
                p.data = f[14+i]; p.last = (i == l - 1); exp_pay.push_back(p);
            end
            s.err_crc = !crc_ok; s.err_len = (l < MINP) || (l > MAXP); s.dropped = 1'b0;
        end
        exp_stat.push_back(s);
    endtask

    task automatic monitor();
        pay_t  p;
        stat_t s;
        hdr_t  h;
        if (payload_valid) begin
            if (exp_pay.size() == 0) check("unexpected_payload", payload_valid, 1'b0);
            else begin
                p = exp_pay.pop_front();
                check("payload_data", payload_out, p.data);
                check("payload_last", payload_last, p.last);
            end
        end
        if (frame_done) begin
            if (exp_stat.size() == 0) check("unexpected_frame_done", frame_done, 1'b0);
            else begin
                s = exp_stat.pop_front();
                if (s.chk_crc) check("err_crc", err_crc, s.err_crc);
                check("err_len", err_len, s.err_len);
                check("dropped", dropped, s.dropped);
                exp_flag = exp_flag | s.err_len | (s.chk_crc & s.err_crc);
                check("error_flag", error_flag, exp_flag);
            end
        end
        if (hdr_valid) begin
            if (exp_hdr.size() == 0) check("unexpected_hdr_valid", hdr_valid, 1'b0);
            else begin
                h = exp_hdr.pop_front();
                check("dst_mac", dst_mac, h.dst);
                check("src_mac", src_mac, h.src);
                check("ethertype", ethertype, h.etype);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        monitor();
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic last);
        valid = 1'b1; frame_in = b; frame_last = last;
        tick();
        valid = 1'b0; frame_last = 1'b0;
    endtask

    task automatic send_frame(input bq_t f, input int gmax);
        for (int i = 0; i < f.size(); i++) begin
            if (i > 0 && gmax > 0) repeat (int'($urandom_range(gmax, 0))) tick();
            drive_byte(f[i], i == f.size() - 1);
        end
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) tick();
        check("left_payload", exp_pay.size(), 0);
        check("left_status", exp_stat.size(), 0);
        check("left_hdr", exp_hdr.size(), 0);
    endtask

    initial begin
        bq_t  f;
        bq_t  g;
        hdr_t h;
        pay_t p;

        rst = 1'b1; valid = 1'b0; frame_in = 8'd0; frame_last = 1'b0;
        repeat (3) tick();
        check("rst_payload_valid", payload_valid, 1'b0);
        check("rst_payload_out", payload_out, 8'd0);
        check("rst_hdr_valid", hdr_valid, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_error_flag", error_flag, 1'b0);
        check("rst_dst_mac", dst_mac, 48'd0);
        check("rst_ethertype", ethertype, 16'd0);
        rst = 1'b0;
        tick();

        // Broadcast, 46-byte payload 0x00..0x2D, good FCS.
        f = build_frame(BCAST, 16'h0800, 46, 8'h00, 1'b0);
        expect_frame(f); send_frame(f, 0); drain(10);

        // Same frame with the last FCS byte flipped; error_flag must stick.
        f = build_frame(BCAST, 16'h0800, 46, 8'h00, 1'b1);
        expect_frame(f); send_frame(f, 0); drain(10);
        check("error_flag_held", error_flag, 1'b1);

        // Foreign unicast destination: filtered.
        f = build_frame(48'h02_00_00_00_00_02, 16'h0800, 50, 8'h33, 1'b0);
        expect_frame(f); send_frame(f, 1); drain(10);

        // 1501-byte payload: truncated after 1500 bytes.
        f = build_frame(LOCAL_MAC, 16'h88B5, 1501, 8'h05, 1'b0);
        expect_frame(f); send_frame(f, 0); drain(10);

        // Exactly MAX_PAYLOAD and one below MIN_PAYLOAD.
        f = build_frame(LOCAL_MAC, 16'h88B6, 1500, 8'h07, 1'b0);
        expect_frame(f); send_frame(f, 0); drain(10);
        f = build_frame(BCAST, 16'h88B7, 45, 8'hA0, 1'b0);
        expect_frame(f); send_frame(f, 0); drain(10);

        // Runt: frame_last inside the header.
        f = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        expect_frame(f); send_frame(f, 0); drain(10);

        // Two 60-byte payload frames back to back with random gaps.
        f = build_frame(BCAST, 16'h0800, 60, 8'h10, 1'b0);
        g = build_frame(LOCAL_MAC, 16'h86DD, 60, 8'h80, 1'b0);
        expect_frame(f); expect_frame(g);
        send_frame(f, 3); send_frame(g, 3); drain(15);

        // Reset at payload byte 20: header and the 16 bytes already pushed
        // out of the delay line are seen; no frame_done follows.
        f = build_frame(LOCAL_MAC, 16'h0806, 50, 8'h40, 1'b0);
        h.dst = LOCAL_MAC; h.src = SRC_MAC; h.etype = 16'h0806;
        exp_hdr.push_back(h);
        for (int i = 0; i < 16; i++) begin
            p.data = f[14+i]; p.last = 1'b0; exp_pay.push_back(p);
        end
        for (int i = 0; i < 34; i++) drive_byte(f[i], 1'b0);
        rst = 1'b1;
        #1;
        exp_flag = 1'b0;
        check("abort_error_flag", error_flag, 1'b0);
        check("abort_payload_valid", payload_valid, 1'b0);
        check("abort_dst_mac", dst_mac, 48'd0);
        repeat (2) tick();
        rst = 1'b0;
        drain(10);
        f = build_frame(BCAST, 16'h0801, 48, 8'hC0, 1'b0);
        expect_frame(f); send_frame(f, 2); drain(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_rx_parser.md
ETH_RX_PARSER -- requirements
Module: eth_rx_parser

Interface
REQ-001 Parameter MAX_PAYLOAD, default 1500, largest accepted payload in bytes.
REQ-002 Parameter MIN_PAYLOAD, default 46, smallest accepted payload in bytes.
REQ-003 Parameter ADDR_FILTER_EN, default 1, enables destination-MAC filtering.
REQ-004 Parameter LOCAL_MAC, default 48'h02_00_00_00_00_01, station address.
REQ-005 clk  input  1  sole clock; all logic rising-edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 frame_in  input  8  frame byte: destination MAC first, FCS last; no preamble or SFD.
REQ-008 valid  input  1  qualifies frame_in; gaps allowed mid-frame.
REQ-009 frame_last  input  1  marks the final FCS byte; meaningful only with valid.
REQ-010 payload_out  output  8  payload byte.
REQ-011 payload_valid  output  1  qualifies payload_out.
REQ-012 payload_last  output  1  marks the final payload byte.
REQ-013 dst_mac, src_mac  output  48 each  header fields, MSB = first byte.
REQ-014 ethertype  output  16  type/length field.
REQ-015 hdr_valid  output  1  one-cycle pulse when all header fields are captured.
REQ-016 frame_done  output  1  one-cycle end-of-frame status pulse.
REQ-017 error_flag  output  1  sticky; set by any err_crc or err_len, cleared only by rst.
REQ-018 err_crc, err_len, dropped  output  1 each  status bits; valid only when frame_done is high.

Function
REQ-019 FSM states: IDLE, HDR, PAYLOAD, DROP, STATUS.
REQ-020 IDLE -> HDR on the first valid byte, which is counted as header byte 0.
REQ-021 HDR captures 14 bytes. hdr_valid pulses in the cycle after byte 13. Next state is DROP if filtered, else PAYLOAD.
REQ-022 A frame is filtered when ADDR_FILTER_EN=1, dst_mac != LOCAL_MAC, and dst_mac != 48'hFFFF_FFFF_FFFF.
REQ-023 PAYLOAD passes bytes through a 4-byte delay line so that FCS bytes never reach payload_out. A byte is emitted on the valid beat that pushes it out of the line.
REQ-024 payload_last is asserted on the last emitted byte. That byte is the one leaving the line on the frame_last beat.
REQ-025 CRC: byte-wise reflected CRC-32, polynomial 0xEDB88320, initialised to 0xFFFFFFFF at frame start. It runs over every valid byte, including the FCS.
REQ-026 Frame passes the CRC check iff the CRC register equals 0xDEBB20E3 after the frame_last byte; otherwise err_crc=1.
REQ-027 Payload count L = total bytes - 18. err_len=1 if L < MIN_PAYLOAD or L > MAX_PAYLOAD.
REQ-028 When the byte count exceeds MAX_PAYLOAD+18 before frame_last, set err_len and enter DROP. Payload output stops immediately, with no payload_last.
REQ-029 DROP discards bytes until frame_last, then goes to STATUS.
REQ-030 STATUS lasts one cycle. frame_done pulses with the status bits, then the FSM returns to IDLE.
REQ-031 dropped=1 when the frame was filtered or truncated by REQ-028. A filtered frame emits no payload and reports err_crc=err_len=0.
REQ-032 frame_last before 14 header bytes: err_len=1, dropped=1, go directly to STATUS.
REQ-033 A valid byte arriving during STATUS is taken as byte 0 of the next frame (zero-gap back-to-back).
REQ-034 The byte counter is 16 bits wide and saturates; it never wraps.
REQ-035 Output latency: one registered cycle from the qualifying valid beat.

Reset
REQ-036 rst clears all outputs, state, counters, delay line and error_flag to 0; the CRC register goes to 0xFFFFFFFF; the FSM goes to IDLE.
REQ-037 rst asserted mid-frame aborts the frame with no frame_done. The next valid byte after rst deasserts is header byte 0.

Structure
REQ-038 Shared package eth_pkg holds the state enum and the constants ETH_HDR_LEN=14, ETH_FCS_LEN=4, CRC_POLY, CRC_INIT, CRC_RESIDUE and BCAST_MAC.
REQ-039 A single sub-module, crc32, performs the byte-wise update with inputs clk, rst, data_in, crc_en, init and output crc_out.

Verification
REQ-040 Broadcast frame, 46-byte payload 0x00..0x2D, correct FCS. Expect 46 payload bytes in order, payload_last on 0x2D, and frame_done with err_crc=0, err_len=0, dropped=0.
REQ-041 The same frame with the last FCS byte flipped. Expect the payload still delivered, err_crc=1 at frame_done, and error_flag set and held.
REQ-042 dst_mac 02:00:00:00:00:02, ADDR_FILTER_EN=1. Expect hdr_valid, no payload_valid, and frame_done with dropped=1.
REQ-043 A 1501-byte payload. Expect exactly 1500 bytes emitted without payload_last, then frame_done with err_len=1, dropped=1.
REQ-044 Two 60-byte frames back-to-back with random valid gaps. Expect two frame_done pulses, both clean, and ethertype captured per frame.
REQ-045 rst asserted at payload byte 20, then a clean frame. Expect no frame_done for the aborted frame and the second frame parsed correctly.
